// File: rtl/charge_detector_pkg.sv
// Shared defaults and helpers for the charge-level detector.
// Latency n/a; no flow control (pure constants and functions).
package charge_detect_pkg;

  localparam int DEF_WIDTH    = 4;
  localparam int DEF_LOW_ON   = 0;
  localparam int DEF_LOW_OFF  = 2;
  localparam int DEF_FULL_ON  = 15;
  localparam int DEF_FULL_OFF = 13;
  localparam int DEF_STABLE   = 2;

  function automatic int cnt_width(input int stable);
    return $clog2(stable) + 1;
  endfunction

endpackage

// File: rtl/charge_detector_if.sv
// Level bus between the charge sensor (master) and the detector (slave).
// Latency n/a; no backpressure, level is sampled every cycle.
interface charge_detector_if
  import charge_detect_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic [WIDTH-1:0] A;
  logic             Y0;
  logic             Y1;

  modport master (output A, input Y0, input Y1);
  modport slave  (input A, output Y0, output Y1);

endinterface

// File: rtl/charge_detector_hyst_debounce.sv
// One debounced flag: toggles after STABLE consecutive cycles of its pending condition.
// Latency STABLE edges from first true condition; no backpressure.
module hyst_debounce
  import charge_detect_pkg::*;
#(
  parameter int STABLE = DEF_STABLE
) (
  input  logic clk,
  input  logic rst_n,
  input  logic set_cond,
  input  logic clr_cond,
  output logic flag
);

  localparam int             CW       = cnt_width(STABLE);
  localparam logic [CW-1:0]  CNT_LAST = CW'(STABLE - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          flag_q, flag_d;
  logic          pend;

  always_comb begin
    cnt_d  = '0;
    flag_d = flag_q;
    pend   = flag_q ? clr_cond : set_cond;
    if (pend) begin
      if (cnt_q == CNT_LAST) begin
        flag_d = ~flag_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      flag_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      flag_q <= flag_d;
    end
  end

  assign flag = flag_q;

endmodule

// File: rtl/charge_detector.sv
// Charge-level monitor: debounced empty (Y0) and full (Y1) flags with hysteresis.
// Latency STABLE+1 edges from A change to flag; no backpressure.
module charge_detector
  import charge_detect_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int LOW_ON   = DEF_LOW_ON,
  parameter int LOW_OFF  = DEF_LOW_OFF,
  parameter int FULL_ON  = DEF_FULL_ON,
  parameter int FULL_OFF = DEF_FULL_OFF,
  parameter int STABLE   = DEF_STABLE
) (
  input  logic             clk,
  input  logic             rst_n,
  charge_detector_if.slave bus
);

  localparam logic [WIDTH-1:0] LOW_ON_V   = WIDTH'(LOW_ON);
  localparam logic [WIDTH-1:0] LOW_OFF_V  = WIDTH'(LOW_OFF);
  localparam logic [WIDTH-1:0] FULL_ON_V  = WIDTH'(FULL_ON);
  localparam logic [WIDTH-1:0] FULL_OFF_V = WIDTH'(FULL_OFF);

  if (!(LOW_ON >= 0 && LOW_ON < LOW_OFF && LOW_OFF <= FULL_OFF &&
        FULL_OFF < FULL_ON && FULL_ON <= (1 << WIDTH) - 1 && STABLE >= 1))
  begin : g_bad_params
    $error("charge_detector: illegal threshold/STABLE parameters");
  end

  logic [WIDTH-1:0] a_q, a_d;
  logic             vld_q, vld_d;
  logic             low_set, low_clr, full_set, full_clr;
  logic             y0, y1;

  // The reset value of a_q is not a real sample: comparators stay
  // quiet until the first sampling edge after release.
  always_comb begin
    a_d   = bus.A;
    vld_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      vld_q <= 1'b0;
    end else begin
      a_q   <= a_d;
      vld_q <= vld_d;
    end
  end

  assign low_set  = vld_q && (a_q <= LOW_ON_V);
  assign low_clr  = vld_q && (a_q >= LOW_OFF_V);
  assign full_set = vld_q && (a_q >= FULL_ON_V);
  assign full_clr = vld_q && (a_q <= FULL_OFF_V);

  hyst_debounce #(.STABLE(STABLE)) u_low (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_cond (low_set),
    .clr_cond (low_clr),
    .flag     (y0)
  );

  hyst_debounce #(.STABLE(STABLE)) u_full (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_cond (full_set),
    .clr_cond (full_clr),
    .flag     (y1)
  );

  assign bus.Y0 = y0;
  assign bus.Y1 = y1;

endmodule

// File: tb/tb_charge_detector.sv
// Bench for charge_detector: reference-model scoreboard per edge plus directed latency checks.
module tb_charge_detector;

  localparam int W      = 4;
  localparam int L_ON   = 0;
  localparam int L_OFF  = 2;
  localparam int F_ON   = 15;
  localparam int F_OFF  = 13;
  localparam int STB    = 2;

  typedef struct {
    bit y0;
    bit y1;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  exp_t sb_q[$];

  // reference model state: sampled level and consecutive-condition run lengths
  int m_a;
  bit m_vld;
  bit m_y0;
  bit m_y1;
  int run0;
  int run1;

  charge_detector_if #(.WIDTH(W)) bus ();

  charge_detector #(
    .WIDTH(W), .LOW_ON(L_ON), .LOW_OFF(L_OFF),
    .FULL_ON(F_ON), .FULL_OFF(F_OFF), .STABLE(STB)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_a  = 0;
    m_vld = 1'b0;
    m_y0 = 1'b0;
    m_y1 = 1'b0;
    run0 = 0;
    run1 = 0;
    sb_q.delete();
  endtask

  task automatic model_edge(input int a_in);
    bit p0;
    bit p1;
    p0 = m_vld && (m_y0 ? (m_a >= L_OFF) : (m_a <= L_ON));
    p1 = m_vld && (m_y1 ? (m_a <= F_OFF) : (m_a >= F_ON));
    run0 = p0 ? run0 + 1 : 0;
    run1 = p1 ? run1 + 1 : 0;
    if (run0 == STB) begin
      m_y0 = ~m_y0;
      run0 = 0;
    end
    if (run1 == STB) begin
      m_y1 = ~m_y1;
      run1 = 0;
    end
    m_a   = a_in;
    m_vld = 1'b1;
  endtask

  // Drive A away from the edge, predict the post-edge flags, compare after the edge.
  task automatic step(input int a_in);
    exp_t e;
    bus.A = W'(a_in);
    model_edge(a_in);
    e.y0 = m_y0;
    e.y1 = m_y1;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    n_checks++;
    if (bus.Y0 !== e.y0 || bus.Y1 !== e.y1) begin
      n_fail++;
      $display("FAIL sb: A=%0d got Y0Y1=%b%b expected %b%b", a_in, bus.Y0, bus.Y1, e.y0, e.y1);
    end
  endtask

  task automatic test_reset();
    int rise;
    rise = 0;
    rst_n = 1'b0;
    bus.A = '0;
    model_reset();
    #1;
    n_checks++;
    if (bus.Y0 !== 1'b0 || bus.Y1 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_val: got Y0Y1=%b%b expected 00", bus.Y0, bus.Y1);
    end
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step(0);
      if (rise == 0 && bus.Y0 === 1'b1) rise = i;
    end
    n_checks++;
    if (rise !== 3) begin
      n_fail++;
      $display("FAIL reset_y0_rise: got edge %0d expected 3", rise);
    end
    n_checks++;
    if (bus.Y1 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_y1_low: got %b expected 0", bus.Y1);
    end
  endtask

  task automatic test_empty_to_full();
    int f0, r1, f1, y0_hi;
    f0 = 0; r1 = 0; f1 = 0; y0_hi = 0;
    for (int i = 1; i <= 6; i++) begin
      step(15);
      if (f0 == 0 && bus.Y0 === 1'b0) f0 = i;
      if (r1 == 0 && bus.Y1 === 1'b1) r1 = i;
    end
    n_checks++;
    if (f0 !== 3 || r1 !== 3) begin
      n_fail++;
      $display("FAIL jump_full: got Y0 fall %0d Y1 rise %0d expected 3 and 3", f0, r1);
    end
    for (int i = 1; i <= 6; i++) begin
      step(6);
      if (f1 == 0 && bus.Y1 === 1'b0) f1 = i;
      if (bus.Y0 === 1'b1) y0_hi++;
    end
    n_checks++;
    if (f1 !== 3) begin
      n_fail++;
      $display("FAIL mid_y1_fall: got edge %0d expected 3", f1);
    end
    n_checks++;
    if (y0_hi !== 0) begin
      n_fail++;
      $display("FAIL mid_y0_low: got %0d high cycles expected 0", y0_hi);
    end
  endtask

  task automatic test_hysteresis();
    int drops, f1;
    drops = 0; f1 = 0;
    repeat (4) step(15);
    n_checks++;
    if (bus.Y1 !== 1'b1) begin
      n_fail++;
      $display("FAIL hyst_setup: got Y1=%b expected 1", bus.Y1);
    end
    repeat (10) begin
      step(14);
      if (bus.Y1 !== 1'b1) drops++;
    end
    n_checks++;
    if (drops !== 0) begin
      n_fail++;
      $display("FAIL hyst_band: got %0d low cycles expected 0", drops);
    end
    for (int i = 1; i <= 5; i++) begin
      step(13);
      if (f1 == 0 && bus.Y1 === 1'b0) f1 = i;
    end
    n_checks++;
    if (f1 !== 3) begin
      n_fail++;
      $display("FAIL hyst_clear: got edge %0d expected 3", f1);
    end
  endtask

  task automatic test_glitch();
    int drops;
    drops = 0;
    repeat (4) step(0);
    n_checks++;
    if (bus.Y0 !== 1'b1) begin
      n_fail++;
      $display("FAIL glitch_setup: got Y0=%b expected 1", bus.Y0);
    end
    step(5);
    if (bus.Y0 !== 1'b1) drops++;
    repeat (5) begin
      step(0);
      if (bus.Y0 !== 1'b1) drops++;
    end
    n_checks++;
    if (drops !== 0) begin
      n_fail++;
      $display("FAIL glitch_hold: got %0d low cycles expected 0", drops);
    end
  endtask

  task automatic test_async_reset();
    int rise;
    rise = 0;
    repeat (4) step(15);
    n_checks++;
    if (bus.Y1 !== 1'b1) begin
      n_fail++;
      $display("FAIL arst_setup: got Y1=%b expected 1", bus.Y1);
    end
    #2;
    rst_n = 1'b0;
    model_reset();
    #2;
    n_checks++;
    if (bus.Y1 !== 1'b0 || bus.Y0 !== 1'b0) begin
      n_fail++;
      $display("FAIL arst_immediate: got Y0Y1=%b%b expected 00", bus.Y0, bus.Y1);
    end
    #2;
    rst_n = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step(15);
      if (rise == 0 && bus.Y1 === 1'b1) rise = i;
    end
    n_checks++;
    if (rise !== 3) begin
      n_fail++;
      $display("FAIL arst_recover: got edge %0d expected 3", rise);
    end
  endtask

  task automatic test_sweep();
    int both, up_bad, dn_bad, up_hi, dn_hi;
    both = 0; up_bad = 0; dn_bad = 0; up_hi = 0; dn_hi = 0;
    repeat (4) step(6);
    for (int v = 0; v <= 15; v++) begin
      repeat (4) begin
        step(v);
        if (bus.Y0 === 1'b1 && bus.Y1 === 1'b1) both++;
        if (bus.Y1 === 1'b1) begin
          up_hi++;
          if (v < 14) up_bad++;
        end
      end
    end
    for (int v = 15; v >= 0; v--) begin
      repeat (4) begin
        step(v);
        if (bus.Y0 === 1'b1 && bus.Y1 === 1'b1) both++;
        if (bus.Y0 === 1'b1) begin
          dn_hi++;
          if (v > 1) dn_bad++;
        end
      end
    end
    n_checks++;
    if (up_bad !== 0 || up_hi == 0) begin
      n_fail++;
      $display("FAIL sweep_up_y1: got %0d high (%0d outside 14-15) expected >0 and 0", up_hi, up_bad);
    end
    n_checks++;
    if (dn_bad !== 0 || dn_hi == 0) begin
      n_fail++;
      $display("FAIL sweep_dn_y0: got %0d high (%0d outside 0-1) expected >0 and 0", dn_hi, dn_bad);
    end
    n_checks++;
    if (both !== 0) begin
      n_fail++;
      $display("FAIL sweep_exclusive: got %0d cycles both high expected 0", both);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    bus.A    = '0;
    model_reset();
    test_reset();
    test_empty_to_full();
    test_hysteresis();
    test_glitch();
    test_async_reset();
    test_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
